// File: rtl/safecrack_btn_driver.sv
// Autoplayer for the safecrack lock: plays a latched one-hot combination as
// active-low button presses, each followed by an all-released gap.
module safecrack_btn_driver #(
  parameter int N_DIGITS    = 3,
  parameter int BTN_W       = 3,
  parameter int HOLD_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N_DIGITS*BTN_W-1:0] code,
  output logic [BTN_W-1:0]          btn_n,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

  state_t                      state, state_nxt;
  logic [TW-1:0]               timer, timer_nxt;
  logic [IW-1:0]               idx, idx_nxt;
  logic [N_DIGITS*BTN_W-1:0]   code_q, code_nxt;
  logic [BTN_W-1:0]            btn_nxt;
  logic                        busy_nxt, done_nxt, err_nxt;
  logic                        code_ok;
  logic [IW-1:0]               idx_inc;

  function automatic logic [BTN_W-1:0] digit_of(input logic [N_DIGITS*BTN_W-1:0] c,
                                                 input logic [IW-1:0] k);
    logic [BTN_W-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (IW'(i) == k) d = c[i*BTN_W +: BTN_W];
    end
    return d;
  endfunction

  always_comb begin
    code_ok = 1'b1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (!$onehot(code[i*BTN_W +: BTN_W])) code_ok = 1'b0;
    end
  end

  assign idx_inc = idx + 1'b1;

  // Outputs are computed one cycle ahead so btn_n/busy/done/err come straight from flops.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    idx_nxt   = idx;
    code_nxt  = code_q;
    btn_nxt   = '1;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          if (code_ok) begin
            code_nxt  = code;
            idx_nxt   = '0;
            timer_nxt = HOLD_LOAD;
            state_nxt = PRESS;
            btn_nxt   = ~code[BTN_W-1:0];
            busy_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      PRESS: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          idx_nxt   = '0;
        end else if (timer == '0) begin
          state_nxt = GAP;
          timer_nxt = GAP_LOAD;
          busy_nxt  = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
          btn_nxt   = ~digit_of(code_q, idx);
          busy_nxt  = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
          timer_nxt = '0;
          idx_nxt   = '0;
        end else if (timer == '0) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = PRESS;
            idx_nxt   = idx_inc;
            timer_nxt = HOLD_LOAD;
            btn_nxt   = ~digit_of(code_q, idx_inc);
            busy_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer - 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      code_q <= '0;
      btn_n  <= '1;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      timer  <= timer_nxt;
      idx    <= idx_nxt;
      code_q <= code_nxt;
      btn_n  <= btn_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_safecrack_btn_driver.sv
// Directed bench for safecrack_btn_driver with HOLD=4, GAP=3 (7 cycles per digit).
module tb_safecrack_btn_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] code = '0;
  logic [2:0] btn_n;
  logic       busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  safecrack_btn_driver #(
    .N_DIGITS(3),
    .BTN_W(3),
    .HOLD_CYCLES(4),
    .GAP_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .code(code),
    .btn_n(btn_n),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_btn"}, 32'(btn_n), 32'h7);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
  endtask

  // kind: 0 none, 1 start with another code, 2 abort, 3 reset
  task automatic run_seq(input logic [8:0] c, input int inj_cyc, input int kind);
    logic [2:0] exp_btn;
    logic       exp_busy, exp_done;
    int         k, w;
    bit         stopped;
    stopped = 0;
    code  = c;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      if (stopped) begin
        exp_btn = 3'b111; exp_busy = 1'b0; exp_done = 1'b0;
      end else if (cyc == 22) begin
        exp_btn = 3'b111; exp_busy = 1'b0; exp_done = 1'b1;
      end else begin
        k = (cyc - 1) / 7;
        w = (cyc - 1) % 7;
        exp_btn  = (w < 4) ? ~c[k*3 +: 3] : 3'b111;
        exp_busy = 1'b1;
        exp_done = 1'b0;
      end
      check("seq_btn", 32'(btn_n), 32'(exp_btn));
      check("seq_busy", 32'(busy), 32'(exp_busy));
      check("seq_done", 32'(done), 32'(exp_done));
      check("seq_err", 32'(err), 32'h0);
      if (cyc == inj_cyc) begin
        if (kind == 1) begin
          start = 1'b1;
          code  = 9'b010_001_100;
        end else if (kind == 2) begin
          abort   = 1'b1;
          stopped = 1;
        end else if (kind == 3) begin
          rst     = 1'b1;
          stopped = 1;
          #1;
          check("rst_async_btn", 32'(btn_n), 32'h7);
          check("rst_async_busy", 32'(busy), 32'h0);
        end
      end
      if (kind == 3 && cyc == inj_cyc + 3) rst = 1'b0;
      tick();
      start = 1'b0;
      abort = 1'b0;
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    // Test 1: reset state and idle after release
    repeat (3) tick();
    check("rst_btn", 32'(btn_n), 32'h7);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check_idle("post_rst");

    // Test 2: nominal playback
    run_seq(9'b100_010_001, 0, 0);

    // Test 3: invalid code (two bits set in digit 1)
    code  = 9'b100_011_001;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_err", 32'(err), 32'h1);
    check_idle("inv");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("inv_err_low", 32'(err), 32'h0);
      check_idle("inv_after");
    end

    // Test 4: start during playback ignored, then abort at second press
    run_seq(9'b001_100_010, 9, 1);
    run_seq(9'b001_100_010, 9, 2);

    // Test 5: reset during third press, then a fresh playback from digit 0
    run_seq(9'b010_001_100, 16, 3);
    check_idle("after_rst_play");
    run_seq(9'b001_010_100, 0, 0);

    // Test 6: abort beats start in IDLE; zero digit is rejected
    code  = 9'b100_010_001;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_err", 32'(err), 32'h0);
    check_idle("abort_start");
    tick();
    check_idle("abort_start2");
    code  = 9'b100_000_001;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_digit_err", 32'(err), 32'h1);
    check_idle("zero_digit");
    tick();
    check("zero_digit_err_low", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/safecrack_btn_driver.md
Name: safecrack_btn_driver

Overview:
Autoplayer that drives the safecrack lock's button inputs. Takes a combination of N_DIGITS one-hot button codes and, on start, emits each digit as an active-low press of fixed hold length followed by a fixed release gap. The timing is built so the lock's 0->1 edge detector sees exactly one clean edge per digit. Used for self-test and demo mode; muxed onto the lock's btn input ahead of the physical keys.

Parameters:
N_DIGITS, 3, number of digits in the combination
BTN_W, 3, number of buttons (width of btn_n and of each digit)
HOLD_CYCLES, 5_000_000, cycles each press is held (100 ms at 50 MHz); must be >= 1
GAP_CYCLES, 5_000_000, cycles of all-released after each press; must be >= 1

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
start  input  1  request to play the combination; sampled only in IDLE
abort  input  1  stop playback, release all buttons
code  input  N_DIGITS*BTN_W  combination; digit i at bits [i*BTN_W +: BTN_W], digit 0 played first; active-high one-hot
btn_n  output  BTN_W  button drive, active-low (1 = released)
busy  output  1  high while a press or gap is being played
done  output  1  one-cycle pulse: full combination played
err  output  1  one-cycle pulse: start rejected, invalid code

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high. All outputs are registered.
- Reset values: btn_n = all ones, busy = 0, done = 0, err = 0, state = IDLE, digit index = 0, timer = 0. rst mid-playback releases all buttons immediately (asynchronously), aborts the sequence, and produces no done.
- States: IDLE, PRESS, GAP.
- IDLE:
  - start=1, abort=0, every digit exactly one-hot: latch code into an internal register, index=0, load timer, go to PRESS.
  - Invalid code (any digit zero or more than one bit set): err=1 for the next cycle only. Stay in IDLE, btn_n unchanged.
  - abort wins over start in the same cycle: nothing happens.
- PRESS:
  - btn_n = ~digit[index] for exactly HOLD_CYCLES cycles, starting the cycle after start is sampled.
  - Then GAP.
- GAP:
  - btn_n = all ones for exactly GAP_CYCLES cycles.
  - Then, if index == N_DIGITS-1: IDLE with done=1 for one cycle, busy=0 in that same cycle.
  - Otherwise: index+1, back to PRESS.
- busy = 1 in every PRESS and GAP cycle, 0 in IDLE.
- Latency: start sampled in cycle T -> done high in cycle T + N_DIGITS*(HOLD_CYCLES+GAP_CYCLES) + 1.
- abort in PRESS or GAP: next cycle btn_n = all ones, busy=0, state IDLE, no done, no err. A start in that cycle is ignored.
- start while busy: ignored. The latched code is not updated; changes to code during playback have no effect.
- Timer:
  - Down-counter, width $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1).
  - Loaded with HOLD_CYCLES-1 or GAP_CYCLES-1 on entry to each phase.
  - Phase ends when the timer reads 0. No wrap-around.
- Digit index: width $clog2(N_DIGITS) (min 1). It never exceeds N_DIGITS-1.
- Exactly one bit of btn_n is low in PRESS. All bits are high otherwise. No glitch between consecutive digits, because GAP always intervenes.

Test Plan:
1. Reset: assert rst mid-sim -> btn_n=3'b111, busy=0, done=0, err=0 within the same cycle. Hold 3 cycles, release -> still idle.
2. HOLD=4, GAP=3, code=9'b100_010_001, start pulsed at T -> btn_n sequence:
   - 110 for T+1..T+4, then 111 x3
   - 101 x4, then 111 x3
   - 011 x4, then 111 x3
   - done=1 only at T+22; busy high T+1..T+21.
3. code=9'b100_011_001, start -> err=1 at T+1 only, busy=0, btn_n=111 throughout, no done.
4. Valid playback; at second PRESS, pulse start with a different code -> ignored, original sequence completes. Rerun and pulse abort at the second PRESS -> next cycle btn_n=111, busy=0, no done.
5. Assert rst during the third PRESS -> btn_n=111 immediately, no done. After release, a new start plays from digit 0.
6. start and abort together in IDLE -> no busy, no err, btn_n=111. code digit 000 with start -> err pulse.
